// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the Sirius execute stage.
// Holds the bus widths, the operation and result-class codes driven by ID/EX,
// the reset/no-op constants, the multiplier FSM state type and small helpers.
package ex_pkg;

    localparam int ALU_OP_W   = 8;
    localparam int ALU_SEL_W  = 3;
    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_W-1:0]      ZERO_WORD     = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = '0;
    localparam logic                  WRITE_DISABLE = 1'b0;

    // Operation codes (aluop)
    localparam logic [ALU_OP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALU_OP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [ALU_OP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [ALU_OP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [ALU_OP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [ALU_OP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [ALU_OP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [ALU_OP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [ALU_OP_W-1:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [ALU_OP_W-1:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [ALU_OP_W-1:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [ALU_OP_W-1:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [ALU_OP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [ALU_OP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;

    // Result classes (alusel)
    localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_ARITH = 3'b100;

    // Iterative multiplier states
    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself,
    // which is still the correct unsigned magnitude.
    function automatic logic [REG_W-1:0] abs_word(input logic [REG_W-1:0] v);
        return v[REG_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: 32-iteration shift-add multiplier for MULT/MULTU.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   start          a multiply op is present on the ID/EX inputs
//   is_signed      1 for MULT, 0 for MULTU
//   abort          pipeline flush; returns to IDLE on the next edge
//   op_a, op_b     raw operands from ID/EX
//   stall          stall request (issue cycle and every BUSY cycle)
//   done           result valid this cycle (DONE state, not aborted)
//   product        signed/unsigned 64-bit product, valid while done
module ex_mul_iter
    import ex_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic               abort,
    input  logic [REG_W-1:0]   op_a,
    input  logic [REG_W-1:0]   op_b,
    output logic               stall,
    output logic               done,
    output logic [2*REG_W-1:0] product
);

    mul_state_e          state;
    mul_state_e          state_nxt;
    logic [REG_W-1:0]    mcand;
    logic [REG_W-1:0]    mplier;
    logic [2*REG_W-1:0]  acc;
    logic [4:0]          cnt;
    logic                neg;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MUL_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a flush overrides everything, including a new issue
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = MUL_IDLE;
        end else begin
            case (state)
                MUL_IDLE: if (start) state_nxt = MUL_BUSY;
                MUL_BUSY: if (cnt == 5'd31) state_nxt = MUL_DONE;
                MUL_DONE: state_nxt = MUL_IDLE;
                default:  state_nxt = MUL_IDLE;
            endcase
        end
    end

    // Datapath: operate on magnitudes and remember the sign separately, so the
    // same unsigned shift-add loop serves both MULT and MULTU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
        end else if (state == MUL_IDLE && start && !abort) begin
            mcand  <= is_signed ? abs_word(op_a) : op_a;
            mplier <= is_signed ? abs_word(op_b) : op_b;
            neg    <= is_signed & (op_a[REG_W-1] ^ op_b[REG_W-1]);
            acc    <= '0;
            cnt    <= '0;
        end else if (state == MUL_BUSY && !abort) begin
            if (mplier[0]) begin
                acc <= acc + ({{REG_W{1'b0}}, mcand} << cnt);
            end
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
        end
    end

    // Outputs: stall from issue through the last BUSY cycle, result in DONE
    always_comb begin
        stall = 1'b0;
        done  = 1'b0;
        case (state)
            MUL_IDLE: stall = start & ~abort;
            MUL_BUSY: stall = ~abort;
            MUL_DONE: done  = ~abort;
            default:  stall = 1'b0;
        endcase
    end

    assign product = neg ? (~acc + 1'b1) : acc;

endmodule

// File: rtl/ex.sv
// ex: execute stage of the Sirius pipeline.
// Evaluates logic/shift/arith ops combinationally and runs MULT/MULTU on the
// iterative multiplier, stalling the pipeline while it works.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   aluop_i, alusel_i  operation and result class from ID/EX
//   reg1_i, reg2_i     operands (shifts: reg1_i[4:0] amount, reg2_i value)
//   wd_i, wreg_i       destination GPR and write enable
//   flush_i            pipeline flush, aborts an in-flight multiply
//   wd_o, wreg_o,
//   wdata_o            GPR write-back to EX/MEM
//   whilo_o, hi_o,
//   lo_o               HI/LO write port to EX/MEM
//   stallreq_o         stall request to pipeline control
module ex
    import ex_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALU_OP_W-1:0]   aluop_i,
    input  logic [ALU_SEL_W-1:0]  alusel_i,
    input  logic [REG_W-1:0]      reg1_i,
    input  logic [REG_W-1:0]      reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic                  whilo_o,
    output logic [REG_W-1:0]      hi_o,
    output logic [REG_W-1:0]      lo_o,
    output logic                  stallreq_o
);

    logic [REG_W-1:0]   logic_res;
    logic [REG_W-1:0]   shift_res;
    logic [REG_W-1:0]   arith_res;
    logic [REG_W-1:0]   sel_res;
    logic               is_mult;
    logic               mul_stall;
    logic               mul_done;
    logic [2*REG_W-1:0] product;

    assign is_mult = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);

    ex_mul_iter u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (is_mult),
        .is_signed (aluop_i == EXE_MULT_OP),
        .abort     (flush_i),
        .op_a      (reg1_i),
        .op_b      (reg2_i),
        .stall     (mul_stall),
        .done      (mul_done),
        .product   (product)
    );

    // Bitwise logic operations
    always_comb begin
        logic_res = ZERO_WORD;
        case (aluop_i)
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = ZERO_WORD;
        endcase
    end

    // Shifts: only the low five bits of reg1 form the amount
    always_comb begin
        shift_res = ZERO_WORD;
        case (aluop_i)
            EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
            EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
            EXE_SRA_OP: shift_res = $signed(reg2_i) >>> reg1_i[4:0];
            default:    shift_res = ZERO_WORD;
        endcase
    end

    // Wrapping add/subtract and set-less-than compares
    always_comb begin
        arith_res = ZERO_WORD;
        case (aluop_i)
            EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
            EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
            EXE_SLT_OP:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
            EXE_SLTU_OP: arith_res = {31'd0, reg1_i < reg2_i};
            EXE_NOP_OP:  arith_res = ZERO_WORD;
            default:     arith_res = ZERO_WORD;
        endcase
    end

    // Result class selection; unknown classes (and NOP) write zero
    always_comb begin
        sel_res = ZERO_WORD;
        case (alusel_i)
            EXE_RES_LOGIC: sel_res = logic_res;
            EXE_RES_SHIFT: sel_res = shift_res;
            EXE_RES_ARITH: sel_res = arith_res;
            default:       sel_res = ZERO_WORD;
        endcase
    end

    // Output muxing. Reset is asynchronous, so outputs are gated with rst
    // directly: an in-flight multiply vanishes the moment rst falls.
    always_comb begin
        wd_o       = NOP_REG_ADDR;
        wreg_o     = WRITE_DISABLE;
        wdata_o    = ZERO_WORD;
        whilo_o    = 1'b0;
        hi_o       = ZERO_WORD;
        lo_o       = ZERO_WORD;
        stallreq_o = 1'b0;
        if (rst) begin
            wd_o       = wd_i;
            wreg_o     = mul_done ? WRITE_DISABLE : wreg_i;
            wdata_o    = sel_res;
            whilo_o    = mul_done;
            stallreq_o = mul_stall;
            if (mul_done) begin
                hi_o = product[2*REG_W-1:REG_W];
                lo_o = product[REG_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_ex.sv
// tb_ex: self-checking bench for the execute stage.
// Single-cycle ops come from a vector table; multiply, flush and reset
// corner cases are hand-written sequences. Expected outputs are queued when
// stimulus is driven and compared when the DUT presents its result.
module tb_ex;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i, flush_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o, lo_o;
    logic        stallreq_o;

    always #5 clk = ~clk;

    ex dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .flush_i    (flush_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        stall;
    } exp_t;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    function automatic exp_t mkExp(logic [4:0] wd, logic wreg, logic [31:0] wdata,
                                   logic whilo, logic [31:0] hi, logic [31:0] lo,
                                   logic stall);
        exp_t e;
        e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.whilo = whilo;
        e.hi = hi; e.lo = lo; e.stall = stall;
        return e;
    endfunction

    function automatic vec_t mkVec(string name, logic [7:0] op, logic [2:0] sel,
                                   logic [31:0] r1, logic [31:0] r2, logic [4:0] wd,
                                   logic wreg, logic [31:0] wdata);
        vec_t v;
        v.name = name; v.op = op; v.sel = sel; v.r1 = r1; v.r2 = r2;
        v.wd = wd; v.wreg = wreg; v.wdata = wdata;
        return v;
    endfunction

    task automatic checkField(string name, logic [63:0] act, logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive ID/EX inputs and queue the outputs they should produce
    task automatic applyStimulus(logic [7:0] op, logic [2:0] sel, logic [31:0] r1,
                                 logic [31:0] r2, logic [4:0] wd, logic wreg,
                                 logic flush, exp_t e);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = r1;
        reg2_i   = r2;
        wd_i     = wd;
        wreg_i   = wreg;
        flush_i  = flush;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare every output against it
    task automatic checkOutput(string name);
        exp_t e;
        if (sb.size() == 0) begin
            checkField({name, " scoreboard empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        checkField({name, " wd_o"},       wd_o,       e.wd);
        checkField({name, " wreg_o"},     wreg_o,     e.wreg);
        checkField({name, " wdata_o"},    wdata_o,    e.wdata);
        checkField({name, " whilo_o"},    whilo_o,    e.whilo);
        checkField({name, " hi_o"},       hi_o,       e.hi);
        checkField({name, " lo_o"},       lo_o,       e.lo);
        checkField({name, " stallreq_o"}, stallreq_o, e.stall);
    endtask

    // Issue a multiply, count stall cycles, then check the DONE cycle
    task automatic runMult(string name, logic [7:0] op, logic [31:0] r1,
                           logic [31:0] r2, logic [31:0] hi, logic [31:0] lo);
        int stalls;
        int busy_whilo;
        @(posedge clk); #1;
        applyStimulus(op, EXE_RES_NOP, r1, r2, 5'd0, 1'b0, 1'b0,
                      mkExp(5'd0, 1'b0, 32'd0, 1'b1, hi, lo, 1'b0));
        stalls = 0;
        busy_whilo = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (stallreq_o !== 1'b1) break;
            stalls++;
            if (whilo_o !== 1'b0) busy_whilo++;
        end
        checkField({name, " stall cycles"}, stalls, 33);
        checkField({name, " whilo during stall"}, busy_whilo, 0);
        checkOutput({name, " done"});
    endtask

    task automatic idleCycle(string name);
        @(posedge clk); #1;
        applyStimulus(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0,
                      mkExp(5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0));
        @(negedge clk);
        checkOutput(name);
    endtask

    initial begin
        int bad_whilo;
        vecs.push_back(mkVec("or",        EXE_OR_OP,   EXE_RES_LOGIC, 32'hFF00FF00, 32'h00FF0000, 5'd1,  1'b1, 32'hFFFFFF00));
        vecs.push_back(mkVec("and",       EXE_AND_OP,  EXE_RES_LOGIC, 32'hFF00FF00, 32'h0F0F0F0F, 5'd2,  1'b1, 32'h0F000F00));
        vecs.push_back(mkVec("xor",       EXE_XOR_OP,  EXE_RES_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F, 5'd3,  1'b0, 32'hF0F00F0F));
        vecs.push_back(mkVec("nor",       EXE_NOR_OP,  EXE_RES_LOGIC, 32'h0000000F, 32'h000000F0, 5'd4,  1'b1, 32'hFFFFFF00));
        vecs.push_back(mkVec("sll",       EXE_SLL_OP,  EXE_RES_SHIFT, 32'd4,        32'h0000000F, 5'd6,  1'b1, 32'h000000F0));
        vecs.push_back(mkVec("srl",       EXE_SRL_OP,  EXE_RES_SHIFT, 32'd4,        32'h80000000, 5'd7,  1'b1, 32'h08000000));
        vecs.push_back(mkVec("sra",       EXE_SRA_OP,  EXE_RES_SHIFT, 32'd4,        32'h80000000, 5'd8,  1'b1, 32'hF8000000));
        vecs.push_back(mkVec("sra amt5",  EXE_SRA_OP,  EXE_RES_SHIFT, 32'h00000024, 32'h80000000, 5'd9,  1'b1, 32'hF8000000));
        vecs.push_back(mkVec("addu wrap", EXE_ADDU_OP, EXE_RES_ARITH, 32'hFFFFFFFF, 32'd2,        5'd10, 1'b1, 32'h00000001));
        vecs.push_back(mkVec("subu wrap", EXE_SUBU_OP, EXE_RES_ARITH, 32'd0,        32'd1,        5'd11, 1'b1, 32'hFFFFFFFF));
        vecs.push_back(mkVec("slt neg",   EXE_SLT_OP,  EXE_RES_ARITH, 32'hFFFFFFFF, 32'd1,        5'd12, 1'b1, 32'd1));
        vecs.push_back(mkVec("sltu",      EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFFFFFF, 32'd1,        5'd13, 1'b1, 32'd0));
        vecs.push_back(mkVec("slt pos",   EXE_SLT_OP,  EXE_RES_ARITH, 32'd1,        32'hFFFFFFFF, 5'd14, 1'b1, 32'd0));
        vecs.push_back(mkVec("nop",       EXE_NOP_OP,  EXE_RES_NOP,   32'd0,        32'd0,        5'd0,  1'b0, 32'd0));
        vecs.push_back(mkVec("bad sel",   EXE_OR_OP,   3'b111,        32'h12345678, 32'h0,        5'd15, 1'b1, 32'd0));

        // Reset held with nonzero inputs, including a multiply op
        rst = 1'b0;
        applyStimulus(EXE_MULT_OP, EXE_RES_LOGIC, 32'hDEADBEEF, 32'h12345678, 5'd31, 1'b1, 1'b0,
                      mkExp(5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0));
        @(negedge clk); @(negedge clk);
        checkOutput("reset");

        // Release reset with an OR already valid: same-cycle result
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000F0F0, 32'h00FF0000, 5'd5, 1'b1, 1'b0,
                      mkExp(5'd5, 1'b1, 32'h00FFF0F0, 1'b0, 32'd0, 32'd0, 1'b0));
        @(negedge clk);
        checkOutput("or after reset");

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            applyStimulus(vecs[i].op, vecs[i].sel, vecs[i].r1, vecs[i].r2, vecs[i].wd, vecs[i].wreg, 1'b0,
                          mkExp(vecs[i].wd, vecs[i].wreg, vecs[i].wdata, 1'b0, 32'd0, 32'd0, 1'b0));
            @(negedge clk);
            checkOutput(vecs[i].name);
        end

        // Signed and unsigned multiplies; the two MULTUs run back to back
        runMult("mult -3x7", EXE_MULT_OP, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        runMult("mult minint x2", EXE_MULT_OP, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'h00000000);
        runMult("multu max", EXE_MULTU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        runMult("multu b2b", EXE_MULTU_OP, 32'd5, 32'd6, 32'd0, 32'd30);
        idleCycle("idle after mult");

        // Flush at BUSY count 10
        @(posedge clk); #1;
        aluop_i = EXE_MULT_OP; alusel_i = EXE_RES_NOP; reg1_i = 32'd5; reg2_i = 32'd5;
        wd_i = 5'd0; wreg_i = 1'b0; flush_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkField("stall before flush", stallreq_o, 1'b1);
        @(posedge clk); #1;
        applyStimulus(EXE_MULT_OP, EXE_RES_NOP, 32'd5, 32'd5, 5'd0, 1'b0, 1'b1,
                      mkExp(5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0));
        @(negedge clk);
        checkOutput("flush cycle");
        idleCycle("after flush");
        bad_whilo = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) bad_whilo++;
        end
        checkField("no hilo write after flush", bad_whilo, 0);

        // Flush coincident with issue: never stalls
        @(posedge clk); #1;
        applyStimulus(EXE_MULT_OP, EXE_RES_NOP, 32'd5, 32'd5, 5'd0, 1'b0, 1'b1,
                      mkExp(5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0));
        @(negedge clk);
        checkOutput("flush on issue");
        idleCycle("after flush on issue");

        // Asynchronous reset in the middle of BUSY
        @(posedge clk); #1;
        aluop_i = EXE_MULT_OP; alusel_i = EXE_RES_NOP; reg1_i = 32'h12345678; reg2_i = 32'd9;
        wd_i = 5'd3; wreg_i = 1'b1; flush_i = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        sb.push_back(mkExp(5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0));
        #1;
        checkOutput("reset mid busy");
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0,
                      mkExp(5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0));
        @(negedge clk);
        checkOutput("after reset release");
        runMult("mult 2x3", EXE_MULT_OP, 32'd2, 32'd3, 32'd0, 32'd6);
        idleCycle("final idle");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
